// File: rtl/reg_writeback_pkg.sv
`default_nettype none
// ============================================================================
// reg_writeback_pkg : shared widths and the write-back request record
// Revision : 1.0
// ============================================================================
package reg_writeback_pkg;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = $clog2(NREG);

  typedef struct packed {
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] data;
  } wb_req_t;

endpackage
`default_nettype wire

// File: rtl/reg_writeback_if.sv
`default_nettype none
// ============================================================================
// reg_writeback_if : ALU/LSU result, scoreboard and RF write-port bundle
// Revision : 1.0
// ============================================================================
interface reg_writeback_if;
  import reg_writeback_pkg::*;

  logic            alu_valid;
  logic            alu_ready;
  logic [AW-1:0]   alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            lsu_valid;
  logic            lsu_ready;
  logic [AW-1:0]   lsu_rd;
  logic [XLEN-1:0] lsu_data;
  logic            sb_set;
  logic [AW-1:0]   sb_rd;
  logic            sb_ready;
  logic [AW-1:0]   rs1;
  logic [AW-1:0]   rs2;
  logic            busy_rs1;
  logic            busy_rs2;
  logic            rf_we;
  logic [AW-1:0]   rf_waddr;
  logic [XLEN-1:0] rf_wdata;

  modport master (
    output alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
    output sb_set, sb_rd, rs1, rs2,
    input  alu_ready, lsu_ready, sb_ready, busy_rs1, busy_rs2,
    input  rf_we, rf_waddr, rf_wdata
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
    input  sb_set, sb_rd, rs1, rs2,
    output alu_ready, lsu_ready, sb_ready, busy_rs1, busy_rs2,
    output rf_we, rf_waddr, rf_wdata
  );

endinterface
`default_nettype wire

// File: rtl/reg_writeback_wb_fifo.sv
`default_nettype none
// ============================================================================
// wb_fifo : synchronous FIFO of write-back requests, wrap-bit full/empty
// Revision : 1.0
// ============================================================================
module wb_fifo
  import reg_writeback_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  wire logic    clk,
  input  wire logic    rst,
  input  wire logic    push,
  input  wire wb_req_t din,
  input  wire logic    pop,
  output wb_req_t      dout,
  output logic         full,
  output logic         empty
);

  localparam int PW = $clog2(DEPTH) + 1;

  wb_req_t         r_mem [DEPTH];
  logic [PW-1:0]   r_wptr;
  logic [PW-1:0]   r_rptr;
  logic            w_do_push;
  logic            w_do_pop;

  assign empty = (r_wptr == r_rptr);
  assign full  = (r_wptr[PW-1] != r_rptr[PW-1]) &&
                 (r_wptr[PW-2:0] == r_rptr[PW-2:0]);
  assign dout  = r_mem[r_rptr[PW-2:0]];

  // A push into a full queue is accepted when the head leaves in the same cycle.
  assign w_do_push = push && (!full || pop);
  assign w_do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr[PW-2:0]] <= din;
  end

endmodule
`default_nettype wire

// File: rtl/reg_writeback.sv
`default_nettype none
// ============================================================================
// reg_writeback : merges ALU and queued load results into one RF write/cycle
// Revision : 1.0
// ============================================================================
module reg_writeback
  import reg_writeback_pkg::*;
#(
  parameter int LQ_DEPTH = 2,
  parameter int CNT_W    = 2
) (
  input  wire logic       clk,
  input  wire logic       rst,
  reg_writeback_if.slave  wb
);

  localparam logic [CNT_W-1:0] c_cnt_max = '1;

  wb_req_t          w_lsu_req;
  wb_req_t          w_head;
  wb_req_t          w_commit_req;
  logic             w_q_full;
  logic             w_q_empty;
  logic             w_push;
  logic             w_alu_commit;
  logic             w_q_commit;
  logic             w_commit;
  logic             w_sb_inc;
  logic [NREG-1:0]  w_inc;
  logic [NREG-1:0]  w_dec;
  logic [CNT_W-1:0] r_cnt [NREG];

  assign w_lsu_req = '{rd: wb.lsu_rd, data: wb.lsu_data};

  wb_fifo #(
    .DEPTH (LQ_DEPTH)
  ) u_load_q (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .din   (w_lsu_req),
    .pop   (w_q_commit),
    .dout  (w_head),
    .full  (w_q_full),
    .empty (w_q_empty)
  );

  // ALU owns the write port unless the load queue is full.
  assign wb.alu_ready = !rst && !w_q_full;
  assign wb.lsu_ready = !rst && !w_q_full;
  assign w_push       = wb.lsu_valid && wb.lsu_ready;
  assign w_alu_commit = wb.alu_valid && wb.alu_ready;
  assign w_q_commit   = !rst && !w_q_empty && !w_alu_commit;
  assign w_commit     = w_alu_commit || w_q_commit;
  assign w_commit_req = w_alu_commit ? '{rd: wb.alu_rd, data: wb.alu_data} : w_head;

  assign wb.sb_ready = (r_cnt[wb.sb_rd] != c_cnt_max);
  assign w_sb_inc    = wb.sb_set && wb.sb_ready && (wb.sb_rd != '0);
  assign wb.busy_rs1 = (wb.rs1 != '0) && (r_cnt[wb.rs1] != '0);
  assign wb.busy_rs2 = (wb.rs2 != '0) && (r_cnt[wb.rs2] != '0);

  always_comb begin
    w_inc = '0;
    w_dec = '0;
    for (int r = 1; r < NREG; r++) begin
      w_inc[r] = w_sb_inc && (wb.sb_rd == AW'(r));
      w_dec[r] = w_q_commit && (w_head.rd == AW'(r)) && (r_cnt[r] != '0);
    end
  end

  // x0 never counts, so its entry simply holds its reset value.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) r_cnt[r] <= '0;
    end else begin
      for (int r = 1; r < NREG; r++) begin
        if (w_inc[r] && !w_dec[r])      r_cnt[r] <= r_cnt[r] + 1'b1;
        else if (w_dec[r] && !w_inc[r]) r_cnt[r] <= r_cnt[r] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wb.rf_we    <= 1'b0;
      wb.rf_waddr <= '0;
      wb.rf_wdata <= '0;
    end else begin
      wb.rf_we <= w_commit && (w_commit_req.rd != '0);
      if (w_commit) begin
        wb.rf_waddr <= w_commit_req.rd;
        wb.rf_wdata <= w_commit_req.data;
      end
    end
  end

  // A load returning to a register decode never marked busy is a protocol error.
  a_no_underflow: assert property (@(posedge clk) disable iff (rst)
    (w_q_commit && (w_head.rd != '0)) |-> (r_cnt[w_head.rd] != '0));

endmodule
`default_nettype wire

// File: tb/tb_reg_writeback.sv
`default_nettype none
// ============================================================================
// tb_reg_writeback : directed vector table, hand sequences, random vs. model
// Revision : 1.0
// ============================================================================
module tb_reg_writeback;
  import reg_writeback_pkg::*;

  localparam int LQ   = 2;
  localparam int CMAX = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  reg_writeback_if bus ();

  reg_writeback #(.LQ_DEPTH(LQ), .CNT_W(2)) dut (
    .clk (clk),
    .rst (rst),
    .wb  (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: load queue, outstanding-load counts, expected RF write.
  wb_req_t    mq[$];
  int         mcnt[32];
  int         pend[32];
  bit         m_we;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata;

  task automatic set_idle();
    bus.alu_valid = 0; bus.alu_rd = '0; bus.alu_data = '0;
    bus.lsu_valid = 0; bus.lsu_rd = '0; bus.lsu_data = '0;
    bus.sb_set = 0; bus.sb_rd = '0; bus.rs1 = '0; bus.rs2 = '0;
  endtask

  task automatic tick(input bit use_model);
    bit      full, f_alu, f_q, f_sb, f_lsu;
    wb_req_t c;
    #1;
    if (rst) begin
      mq.delete();
      for (int r = 0; r < 32; r++) begin mcnt[r] = 0; pend[r] = 0; end
      m_we = 0;
    end else begin
      full = (mq.size() == LQ);
      if (use_model) begin
        check("alu_ready", bus.alu_ready, !full);
        check("lsu_ready", bus.lsu_ready, !full);
        check("sb_ready", bus.sb_ready, mcnt[bus.sb_rd] != CMAX);
        check("busy_rs1", bus.busy_rs1, (bus.rs1 != 0) && (mcnt[bus.rs1] != 0));
        check("busy_rs2", bus.busy_rs2, (bus.rs2 != 0) && (mcnt[bus.rs2] != 0));
      end
      f_alu = bus.alu_valid && !full;
      f_q   = !f_alu && (mq.size() > 0);
      f_sb  = bus.sb_set && (mcnt[bus.sb_rd] != CMAX) && (bus.sb_rd != 0);
      f_lsu = bus.lsu_valid && !full;
      if (f_alu)    c = '{rd: bus.alu_rd, data: bus.alu_data};
      else if (f_q) c = mq[0];
      else          c = '0;
      m_we = (f_alu || f_q) && (c.rd != 0);
      if (f_alu || f_q) begin m_waddr = c.rd; m_wdata = c.data; end
      if (f_sb) begin mcnt[bus.sb_rd]++; pend[bus.sb_rd]++; end
      if (f_q) begin
        if (mq[0].rd != 0 && mcnt[mq[0].rd] > 0) mcnt[mq[0].rd]--;
        void'(mq.pop_front());
      end
      if (f_lsu) begin
        mq.push_back('{rd: bus.lsu_rd, data: bus.lsu_data});
        if (bus.lsu_rd != 0 && pend[bus.lsu_rd] > 0) pend[bus.lsu_rd]--;
      end
    end
    @(posedge clk);
    #1;
    if (use_model) begin
      check("rf_we", bus.rf_we, m_we);
      if (m_we) begin
        check("rf_waddr", bus.rf_waddr, m_waddr);
        check("rf_wdata", bus.rf_wdata, m_wdata);
      end
    end
  endtask

  typedef struct {
    logic rst;
    logic alu_v; logic [4:0] alu_rd; logic [31:0] alu_d;
    logic lsu_v; logic [4:0] lsu_rd; logic [31:0] lsu_d;
    logic sb_set; logic [4:0] sb_rd; logic [4:0] rs1;
    logic chk;
    logic e_alu; logic e_lsu; logic e_sb; logic e_busy;
    logic e_we; logic [4:0] e_waddr; logic [31:0] e_wdata;
  } vec_t;

  vec_t vt[15];

  task automatic reset_dut();
    set_idle();
    rst = 1;
    tick(1);
    tick(1);
    rst = 0;
  endtask

  initial begin
    int start, r, pick;
    rst = 1;
    set_idle();
    //        rst alu          lsu                sb      rs1 chk  a l s b  we addr data
    vt[0]  = '{1, 1, 1, 32'h11, 1, 2, 32'h22,       1, 2, 0, 0,  0,0,0,0, 0, 0, 0};
    vt[1]  = '{1, 1, 1, 32'h11, 1, 2, 32'h22,       1, 2, 0, 1,  0,0,0,0, 0, 0, 0};
    vt[2]  = '{0, 0, 0, 0,      0, 0, 0,            1, 4, 4, 1,  1,1,1,0, 0, 0, 0};
    vt[3]  = '{0, 1, 5, 32'hDEADBEEF, 0, 0, 0,      0, 0, 4, 1,  1,1,1,1, 1, 5, 32'hDEADBEEF};
    vt[4]  = '{0, 0, 0, 0,      0, 0, 0,            0, 0, 4, 1,  1,1,1,1, 0, 0, 0};
    vt[5]  = '{0, 1, 3, 32'h1,  1, 4, 32'h2,        0, 0, 4, 1,  1,1,1,1, 1, 3, 32'h1};
    vt[6]  = '{0, 0, 0, 0,      0, 0, 0,            0, 0, 4, 1,  1,1,1,1, 1, 4, 32'h2};
    vt[7]  = '{0, 0, 0, 0,      0, 0, 0,            0, 0, 4, 1,  1,1,1,0, 0, 0, 0};
    vt[8]  = '{0, 0, 0, 0,      0, 0, 0,            1, 8, 0, 1,  1,1,1,0, 0, 0, 0};
    vt[9]  = '{0, 1, 10, 32'hA, 1, 8, 32'hAAAA0008, 1, 9, 0, 1,  1,1,1,0, 1, 10, 32'hA};
    vt[10] = '{0, 1, 11, 32'hB, 1, 9, 32'hBBBB0009, 0, 0, 0, 1,  1,1,1,0, 1, 11, 32'hB};
    vt[11] = '{0, 1, 12, 32'hC, 0, 0, 0,            0, 0, 8, 1,  0,0,1,1, 1, 8, 32'hAAAA0008};
    vt[12] = '{0, 1, 12, 32'hC, 0, 0, 0,            0, 0, 8, 1,  1,1,1,0, 1, 12, 32'hC};
    vt[13] = '{0, 0, 0, 0,      0, 0, 0,            0, 0, 9, 1,  1,1,1,1, 1, 9, 32'hBBBB0009};
    vt[14] = '{0, 0, 0, 0,      0, 0, 0,            0, 0, 9, 1,  1,1,1,0, 0, 0, 0};

    @(posedge clk);
    #1;
    for (int i = 0; i < 15; i++) begin
      rst = vt[i].rst;
      bus.alu_valid = vt[i].alu_v; bus.alu_rd = vt[i].alu_rd; bus.alu_data = vt[i].alu_d;
      bus.lsu_valid = vt[i].lsu_v; bus.lsu_rd = vt[i].lsu_rd; bus.lsu_data = vt[i].lsu_d;
      bus.sb_set = vt[i].sb_set; bus.sb_rd = vt[i].sb_rd; bus.rs1 = vt[i].rs1; bus.rs2 = '0;
      #1;
      if (vt[i].chk) begin
        check($sformatf("v%0d busy_rs1", i), bus.busy_rs1, vt[i].e_busy);
        if (!vt[i].rst) begin
          check($sformatf("v%0d alu_ready", i), bus.alu_ready, vt[i].e_alu);
          check($sformatf("v%0d lsu_ready", i), bus.lsu_ready, vt[i].e_lsu);
          check($sformatf("v%0d sb_ready", i), bus.sb_ready, vt[i].e_sb);
        end
      end
      tick(0);
      check($sformatf("v%0d rf_we", i), bus.rf_we, vt[i].e_we);
      if (vt[i].e_we) begin
        check($sformatf("v%0d rf_waddr", i), bus.rf_waddr, vt[i].e_waddr);
        check($sformatf("v%0d rf_wdata", i), bus.rf_wdata, vt[i].e_wdata);
      end
    end

    // Scoreboard: saturate r7, then simultaneous set and load commit.
    reset_dut();
    for (int k = 0; k < 3; k++) begin set_idle(); bus.sb_set = 1; bus.sb_rd = 7; tick(1); end
    set_idle(); bus.sb_set = 1; bus.sb_rd = 7; bus.rs1 = 7;
    #1;
    check("sb_sat sb_ready", bus.sb_ready, 0);
    check("sb_sat busy_rs1", bus.busy_rs1, 1);
    tick(1);
    set_idle(); bus.lsu_valid = 1; bus.lsu_rd = 7; bus.lsu_data = 32'h71;
    bus.alu_valid = 1; bus.alu_rd = 20; bus.alu_data = 32'h20; tick(1);
    set_idle(); bus.lsu_valid = 1; bus.lsu_rd = 7; bus.lsu_data = 32'h72;
    bus.alu_valid = 1; bus.alu_rd = 21; bus.alu_data = 32'h21; tick(1);
    set_idle(); tick(1);
    set_idle(); bus.sb_set = 1; bus.sb_rd = 7;
    #1;
    check("sb_both sb_ready", bus.sb_ready, 1);
    tick(1);
    set_idle(); bus.sb_rd = 7; bus.rs1 = 7;
    #1;
    check("sb_after_both sb_ready", bus.sb_ready, 1);
    tick(1);
    set_idle(); bus.sb_set = 1; bus.sb_rd = 7; tick(1);
    set_idle(); bus.sb_rd = 7;
    #1;
    check("sb_resat sb_ready", bus.sb_ready, 0);
    tick(1);
    for (int k = 0; k < 3; k++) begin
      set_idle(); bus.lsu_valid = 1; bus.lsu_rd = 7; bus.lsu_data = 32'h73 + k; bus.rs1 = 7; tick(1);
    end
    set_idle(); bus.rs1 = 7;
    #1;
    check("drain busy_before", bus.busy_rs1, 1);
    tick(1);
    check("drain last rf_we", bus.rf_we, 1);
    check("drain last rf_waddr", bus.rf_waddr, 7);
    check("drain busy_after", bus.busy_rs1, 0);

    // x0 loads: consumed from the queue, never written, never busy.
    reset_dut();
    set_idle(); bus.lsu_valid = 1; bus.lsu_rd = 0; bus.lsu_data = 32'h99;
    bus.sb_set = 1; bus.sb_rd = 0; bus.alu_valid = 1; bus.alu_rd = 22; bus.alu_data = 32'h22; tick(1);
    set_idle(); bus.lsu_valid = 1; bus.lsu_rd = 0; bus.lsu_data = 32'h98;
    bus.alu_valid = 1; bus.alu_rd = 23; bus.alu_data = 32'h23; tick(1);
    set_idle();
    #1;
    check("x0 full lsu_ready", bus.lsu_ready, 0);
    check("x0 busy_rs1", bus.busy_rs1, 0);
    tick(1);
    check("x0 pop1 rf_we", bus.rf_we, 0);
    set_idle(); tick(1);
    check("x0 pop2 rf_we", bus.rf_we, 0);
    set_idle();
    #1;
    check("x0 drained lsu_ready", bus.lsu_ready, 1);
    tick(1);

    // Randomised traffic against the model, with occasional mid-run resets.
    reset_dut();
    for (int n = 0; n < 800; n++) begin
      set_idle();
      rst = ($urandom_range(0, 99) == 0);
      bus.alu_valid = 1'($urandom_range(0, 1));
      bus.alu_rd    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      bus.alu_data  = $urandom;
      bus.sb_set    = 1'($urandom_range(0, 1));
      bus.sb_rd     = 5'($urandom_range(0, 7));
      bus.rs1       = 5'($urandom_range(0, 7));
      bus.rs2       = 5'($urandom_range(0, 7));
      start = $urandom_range(1, 7);
      pick  = 0;
      for (int k = 0; k < 7; k++) begin
        r = 1 + ((start - 1 + k) % 7);
        if (pick == 0 && pend[r] > 0) pick = r;
      end
      if (pick != 0 && $urandom_range(0, 3) != 0) begin
        bus.lsu_valid = 1; bus.lsu_rd = 5'(pick); bus.lsu_data = $urandom;
      end else if ($urandom_range(0, 7) == 0) begin
        bus.lsu_valid = 1; bus.lsu_rd = 5'd0; bus.lsu_data = $urandom;
      end
      tick(1);
    end
    rst = 0;
    set_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
